gnn_layer_sequencer: RTL and testbench

- Control FSM for the 4-node GNN inference datapath.
- Sequences each layer's aggregation phase, then its weight/MAC phase, over every node and neuron, one step per cycle.
- Steps one shared MAC unit through all (node, neuron) pairs.
- After the last (output) layer, streams per-node results out with a valid/ready handshake.
- Sits between the input-load logic (in_ready) and the aggregation/MAC/output-register datapath.

---
 rtl/gnn_layer_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_gnn_layer_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gnn_layer_sequencer.sv
// Control FSM for the 4-node GNN datapath: per-layer aggregation, then MAC stepping, then output streaming.
// Optional perf counters are enabled by defining GNN_SEQ_PERF_CNT_EN.
module gnn_layer_sequencer #(
  parameter int NUM_NODES   = 4,
  parameter int NUM_LAYERS  = 4,
  parameter int HID_NEURONS = 4,
  parameter int OUT_NEURONS = 2,
  localparam int MAX_NEURONS = (HID_NEURONS > OUT_NEURONS) ? HID_NEURONS : OUT_NEURONS,
  localparam int NODE_W  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int NEUR_W  = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1,
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_ready,
  output logic               busy,
  output logic               aggr_en,
  output logic               layer_en,
  output logic               acc_clr,
  output logic [NODE_W-1:0]  node_idx,
  output logic [NEUR_W-1:0]  neuron_idx,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done,
  output logic [15:0]        perf_busy_cycles,
  output logic [15:0]        perf_stall_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AGGR  = 2'd1,
    LAYER = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [NODE_W-1:0]  NODE_LAST  = NODE_W'(NUM_NODES - 1);
  localparam logic [NEUR_W-1:0]  HID_LAST   = NEUR_W'(HID_NEURONS - 1);
  localparam logic [NEUR_W-1:0]  OUT_LAST   = NEUR_W'(OUT_NEURONS - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  state_t               state_r, state_s;
  logic [NODE_W-1:0]    node_r, node_s;
  logic [NEUR_W-1:0]    neuron_r, neuron_s, neur_last_s;
  logic [LAYER_W-1:0]   layer_r, layer_s;
  logic                 done_s;
  logic                 busy_r, aggr_en_r, layer_en_r, acc_clr_r, out_valid_r, done_r;

  // Next-state and index sequencing; indices not used by a phase keep their last value.
  always_comb begin
    state_s  = state_r;
    node_s   = node_r;
    neuron_s = neuron_r;
    layer_s  = layer_r;
    done_s   = 1'b0;
    if (layer_r == LAYER_LAST) begin
      neur_last_s = OUT_LAST;
    end else begin
      neur_last_s = HID_LAST;
    end
    case (state_r)
      IDLE: begin
        if (in_ready) begin
          state_s  = AGGR;
          node_s   = '0;
          neuron_s = '0;
          layer_s  = '0;
        end else begin
          state_s  = IDLE;
        end
      end
      AGGR: begin
        if (node_r == NODE_LAST) begin
          state_s  = LAYER;
          node_s   = '0;
          neuron_s = '0;
        end else begin
          node_s   = node_r + NODE_W'(1);
        end
      end
      LAYER: begin
        if (neuron_r != neur_last_s) begin
          neuron_s = neuron_r + NEUR_W'(1);
        end else if (node_r != NODE_LAST) begin
          neuron_s = '0;
          node_s   = node_r + NODE_W'(1);
        end else if (layer_r == LAYER_LAST) begin
          state_s  = OUT;
          node_s   = '0;
        end else begin
          state_s  = AGGR;
          node_s   = '0;
          layer_s  = layer_r + LAYER_W'(1);
        end
      end
      OUT: begin
        if (out_ready && (node_r == NODE_LAST)) begin
          state_s  = IDLE;
          done_s   = 1'b1;
        end else if (out_ready) begin
          node_s   = node_r + NODE_W'(1);
        end else begin
          node_s   = node_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, indices and output flags; flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      node_r      <= '0;
      neuron_r    <= '0;
      layer_r     <= '0;
      busy_r      <= 1'b0;
      aggr_en_r   <= 1'b0;
      layer_en_r  <= 1'b0;
      acc_clr_r   <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      node_r      <= node_s;
      neuron_r    <= neuron_s;
      layer_r     <= layer_s;
      busy_r      <= (state_s != IDLE);
      aggr_en_r   <= (state_s == AGGR);
      layer_en_r  <= (state_s == LAYER);
      acc_clr_r   <= (state_s == LAYER) && (node_s == '0) && (neuron_s == '0);
      out_valid_r <= (state_s == OUT);
      done_r      <= done_s;
    end
  end

  assign busy       = busy_r;
  assign aggr_en    = aggr_en_r;
  assign layer_en   = layer_en_r;
  assign acc_clr    = acc_clr_r;
  assign out_valid  = out_valid_r;
  assign done       = done_r;
  assign node_idx   = node_r;
  assign neuron_idx = neuron_r;
  assign layer_idx  = layer_r;

`ifdef GNN_SEQ_PERF_CNT_EN
  logic [15:0] perf_busy_r, perf_stall_r;

  // Saturating activity counters, cleared when a new inference is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_r  <= 16'd0;
      perf_stall_r <= 16'd0;
    end else if ((state_r == IDLE) && in_ready) begin
      perf_busy_r  <= 16'd0;
      perf_stall_r <= 16'd0;
    end else begin
      if (busy_r && (perf_busy_r != 16'hFFFF)) begin
        perf_busy_r <= perf_busy_r + 16'd1;
      end else begin
        perf_busy_r <= perf_busy_r;
      end
      if (out_valid_r && !out_ready && (perf_stall_r != 16'hFFFF)) begin
        perf_stall_r <= perf_stall_r + 16'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_busy_cycles  = perf_busy_r;
  assign perf_stall_cycles = perf_stall_r;
`else
  assign perf_busy_cycles  = 16'd0;
  assign perf_stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_gnn_layer_sequencer.sv
// Directed bench for gnn_layer_sequencer: cycle timeline checks plus an output-beat scoreboard.
module tb_gnn_layer_sequencer;

`ifdef GNN_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_ready, out_ready;
  logic        busy, aggr_en, layer_en, acc_clr, out_valid, done;
  logic [1:0]  node_idx, neuron_idx, layer_idx;
  logic [15:0] perf_busy_cycles, perf_stall_cycles;

  int checks = 0;
  int errors = 0;
  int out_q[$];

  gnn_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .busy(busy),
    .aggr_en(aggr_en), .layer_en(layer_en), .acc_clr(acc_clr),
    .node_idx(node_idx), .neuron_idx(neuron_idx), .layer_idx(layer_idx),
    .out_valid(out_valid), .out_ready(out_ready), .done(done),
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the expected node for every beat the consumer takes this cycle.
  task automatic beat(input int c);
    int e;
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) begin
        chk($sformatf("c%0d unexpected_beat", c), 32'd1, 32'd0);
      end else begin
        e = out_q.pop_front();
        chk($sformatf("c%0d beat_node", c), node_idx, e);
      end
    end
  endtask

  task automatic start();
    in_ready = 1'b1;
    for (int n = 0; n < 4; n++) out_q.push_back(n);
    tick();
    in_ready = 1'b0;
  endtask

  // Expected outputs for cycle c after start acceptance, with out_ready held high.
  task automatic check_nominal(input int c);
    int p, q, nn, lay, node, neu;
    logic e_busy, e_aggr, e_layer, e_clr, e_ov, e_done, chk_node, chk_neu;
    e_busy = 1'b0; e_aggr = 1'b0; e_layer = 1'b0; e_clr = 1'b0; e_ov = 1'b0; e_done = 1'b0;
    chk_node = 1'b1; chk_neu = 1'b0; node = 0; neu = 0; lay = 3;
    if (c <= 72) begin
      e_busy = 1'b1;
      if (c <= 60) begin
        lay = (c - 1) / 20; p = (c - 1) % 20; nn = 4;
      end else begin
        lay = 3; p = c - 61; nn = 2;
      end
      if (p < 4) begin
        e_aggr = 1'b1; node = p;
      end else begin
        q = p - 4; e_layer = 1'b1; node = q / nn; neu = q % nn;
        chk_neu = 1'b1; e_clr = (q == 0);
      end
    end else if (c <= 76) begin
      e_busy = 1'b1; e_ov = 1'b1; node = c - 73;
    end else begin
      e_done = 1'b1; chk_node = 1'b0;
    end
    chk($sformatf("c%0d busy", c), busy, e_busy);
    chk($sformatf("c%0d aggr_en", c), aggr_en, e_aggr);
    chk($sformatf("c%0d layer_en", c), layer_en, e_layer);
    chk($sformatf("c%0d acc_clr", c), acc_clr, e_clr);
    chk($sformatf("c%0d out_valid", c), out_valid, e_ov);
    chk($sformatf("c%0d done", c), done, e_done);
    chk($sformatf("c%0d layer_idx", c), layer_idx, lay);
    if (chk_node) chk($sformatf("c%0d node_idx", c), node_idx, node);
    if (chk_neu) chk($sformatf("c%0d neuron_idx", c), neuron_idx, neu);
  endtask

  task automatic run_nominal(input int c_from, input int c_to);
    for (int c = c_from; c <= c_to; c++) begin
      check_nominal(c);
      beat(c);
      tick();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " aggr_en"}, aggr_en, 1'b0);
    chk({tag, " layer_en"}, layer_en, 1'b0);
    chk({tag, " acc_clr"}, acc_clr, 1'b0);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " node_idx"}, node_idx, 2'd0);
    chk({tag, " neuron_idx"}, neuron_idx, 2'd0);
    chk({tag, " layer_idx"}, layer_idx, 2'd0);
    chk({tag, " perf_busy"}, perf_busy_cycles, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_ready = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // Nominal inference with the consumer always ready.
    start();
    run_nominal(1, 76);
    check_nominal(77);
    chk("c77 perf_busy", perf_busy_cycles, PERF ? 32'd76 : 32'd0);
    chk("c77 perf_stall", perf_stall_cycles, 32'd0);
    tick();
    chk("c78 idle done", done, 1'b0);
    chk("c78 idle busy", busy, 1'b0);
    chk("c78 perf_busy held", perf_busy_cycles, PERF ? 32'd76 : 32'd0);

    // Backpressure for five cycles while node 2 is presented.
    start();
    chk("bp c1 perf_busy cleared", perf_busy_cycles, 32'd0);
    run_nominal(1, 74);
    for (int c = 75; c <= 82; c++) begin
      out_ready = (c <= 79) ? 1'b0 : 1'b1;
      chk($sformatf("bp c%0d out_valid", c), out_valid, (c <= 81) ? 1'b1 : 1'b0);
      chk($sformatf("bp c%0d busy", c), busy, (c <= 81) ? 1'b1 : 1'b0);
      chk($sformatf("bp c%0d done", c), done, (c == 82) ? 1'b1 : 1'b0);
      if (c <= 80) chk($sformatf("bp c%0d node_idx", c), node_idx, 2'd2);
      if (c == 81) chk("bp c81 node_idx", node_idx, 2'd3);
      beat(c);
      tick();
    end
    out_ready = 1'b1;
    chk("bp perf_stall", perf_stall_cycles, PERF ? 32'd5 : 32'd0);
    chk("bp perf_busy", perf_busy_cycles, PERF ? 32'd81 : 32'd0);
    tick();

    // in_ready raised mid-run is ignored, then accepted in the done cycle.
    start();
    run_nominal(1, 29);
    in_ready = 1'b1;
    run_nominal(30, 76);
    check_nominal(77);
    for (int n = 0; n < 4; n++) out_q.push_back(n);
    tick();
    in_ready = 1'b0;
    run_nominal(1, 39);
    check_nominal(40);

    // Reset in the middle of the restarted inference.
    rst_n = 1'b0;
    tick();
    check_reset_state("midrst");
    out_q.delete();
    rst_n = 1'b1;
    tick();
    chk("post_rst busy", busy, 1'b0);
    chk("post_rst done", done, 1'b0);
    tick();
    chk("post_rst2 done", done, 1'b0);

    // Fresh start reproduces nominal timing.
    start();
    run_nominal(1, 77);
    chk("final perf_busy", perf_busy_cycles, PERF ? 32'd76 : 32'd0);
    chk("queue_empty", out_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
